// File: rtl/rr_dff_write_arbiter.sv
// ---------------------------------------------------------------------------
// rr_dff_write_arbiter
//
// Round-robin arbiter and sequencer that shares one DATA_W-bit register (q)
// between NUM_REQ requesters. One requester is granted at a time. Its data is
// captured into q and acknowledged with a single-cycle ack. An optional
// cooldown of COOL_CYCLES cycles follows each completed write.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - asynchronous active-low reset
//   req      - per-requester write request (level, held until ack)
//   wdata    - packed write data, lane i at [i*DATA_W +: DATA_W]
//   clr      - synchronous clear of q (highest priority on q)
//   grant    - registered one-hot grant, zero when no grant is active
//   ack      - one-cycle pulse: the granted write landed in q
//   q        - shared register contents
//   last_id  - index of the requester whose write last completed
//   busy     - high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module rr_dff_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int COOL_CYCLES = 1,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    input  logic                      clr,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      ack,
    output logic [DATA_W-1:0]         q,
    output logic [ID_W-1:0]           last_id,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ID_W-1:0]   ptr_reg;
    logic [ID_W-1:0]   gid_reg;
    logic [ID_W-1:0]   ptr_after;
    logic [ID_W-1:0]   pick_id;
    logic              pick_valid;
    logic [3:0]        cool_cnt_reg;
    logic              write_ok;
    logic [DATA_W-1:0] lane [NUM_REQ];

    // Unpack the write data lanes.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane[gi] = wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The granted requester still holds its request: the write completes.
    assign write_ok = (state_reg == GRANT) && req[gid_reg];

    // Pointer moves one past the requester that just completed, wrapping.
    assign ptr_after = (gid_reg == ID_W'(NUM_REQ - 1)) ? '0 : gid_reg + ID_W'(1);

    // Priority search starting at ptr_reg and wrapping. The loop runs from
    // the farthest offset down so the nearest set bit is the one kept.
    always_comb begin
        int idx;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr_reg) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[ID_W'(idx)]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (write_ok && (COOL_CYCLES > 0)) begin
                    state_next = COOL;
                end else begin
                    state_next = IDLE;
                end
            end
            COOL: begin
                // Leave on the edge where the counter reaches zero.
                if (cool_cnt_reg <= 4'd1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state_reg != IDLE);
    end

    // Datapath and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant        <= '0;
            ack          <= 1'b0;
            q            <= '0;
            last_id      <= '0;
            ptr_reg      <= '0;
            gid_reg      <= '0;
            cool_cnt_reg <= '0;
        end else begin
            ack <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
                        gid_reg <= pick_id;
                    end
                end
                GRANT: begin
                    grant <= '0;
                    if (write_ok) begin
                        last_id      <= gid_reg;
                        ptr_reg      <= ptr_after;
                        cool_cnt_reg <= 4'(COOL_CYCLES);
                        // A coinciding clear drops the data and the ack.
                        if (!clr) begin
                            q   <= lane[gid_reg];
                            ack <= 1'b1;
                        end
                    end
                end
                COOL: begin
                    cool_cnt_reg <= cool_cnt_reg - 4'd1;
                end
                default: begin
                    grant <= '0;
                end
            endcase
            // Clear wins over any write to q.
            if (clr) begin
                q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_dff_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_dff_write_arbiter
//
// Bench for rr_dff_write_arbiter. Instance a has no cooldown, instance b has
// a three-cycle cooldown; both share stimulus. A table of per-cycle vectors
// covers reset release and round-robin order; hand-written sequences cover
// wrap/skip, abort, clear collisions, cooldown and reset mid-transaction.
// Expected write results are queued when stimulus is driven and compared
// whenever the selected instance pulses ack.
// ---------------------------------------------------------------------------
module tb_rr_dff_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic           clr;

    logic [N-1:0]   grant_a, grant_b;
    logic           ack_a, ack_b;
    logic [W-1:0]   q_a, q_b;
    logic [1:0]     id_a, id_b;
    logic           busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [1:0]   id;
    } wr_t;

    wr_t sb[$];
    int  mon_sel;
    bit  mon_en;

    typedef struct {
        logic [N-1:0] req;
        logic         clr;
        logic [N-1:0] grant;
        logic         ack;
        logic [W-1:0] q;
        logic [1:0]   id;
        logic         busy;
    } vec_t;

    vec_t tbl[10];

    rr_dff_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .COOL_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .clr(clr),
        .grant(grant_a), .ack(ack_a), .q(q_a), .last_id(id_a), .busy(busy_a)
    );

    rr_dff_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .COOL_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .clr(clr),
        .grant(grant_b), .ack(ack_b), .q(q_b), .last_id(id_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] qv, input logic [1:0] idv);
        wr_t e;
        e.q  = qv;
        e.id = idv;
        sb.push_back(e);
    endtask

    // Scoreboard monitor on the selected instance.
    logic         m_ack;
    logic [W-1:0] m_q;
    logic [1:0]   m_id;
    wr_t          m_exp;

    always @(negedge clk) begin
        if (mon_en) begin
            m_ack = (mon_sel == 0) ? ack_a : ack_b;
            m_q   = (mon_sel == 0) ? q_a : q_b;
            m_id  = (mon_sel == 0) ? id_a : id_b;
            if (m_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_ack: got ack=1 q=%02h, required no ack", m_q);
                end else begin
                    m_exp = sb.pop_front();
                    chk("sb_q", 32'(m_q), 32'(m_exp.q));
                    chk("sb_id", 32'(m_id), 32'(m_exp.id));
                    $display("ack dut%0d q=%02h last_id=%0d (expected %02h/%0d)",
                             mon_sel, m_q, m_id, m_exp.q, m_exp.id);
                end
            end
        end
    end

    initial begin
        // Reset release then round robin on instance a, one row per cycle.
        tbl[0] = '{4'b1111, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1};
        tbl[1] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b0};
        tbl[2] = '{4'b1111, 1'b0, 4'b0010, 1'b0, 8'h11, 2'd0, 1'b1};
        tbl[3] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b0};
        tbl[4] = '{4'b1111, 1'b0, 4'b0100, 1'b0, 8'h22, 2'd1, 1'b1};
        tbl[5] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b0};
        tbl[6] = '{4'b1111, 1'b0, 4'b1000, 1'b0, 8'h33, 2'd2, 1'b1};
        tbl[7] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3, 1'b0};
        tbl[8] = '{4'b1111, 1'b0, 4'b0001, 1'b0, 8'h44, 2'd3, 1'b1};
        tbl[9] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b0};

        reset   = 1'b0;
        req     = 4'b1111;
        clr     = 1'b0;
        wdata   = {8'h44, 8'h33, 8'h22, 8'h11};
        mon_sel = 0;
        mon_en  = 1'b1;

        // Held in reset with requests pending.
        repeat (2) cyc();
        chk("rst_q", 32'(q_a), 32'h0);
        chk("rst_grant", 32'(grant_a), 32'h0);
        chk("rst_ack", 32'(ack_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_last_id", 32'(id_a), 32'h0);
        chk("rst_grant_b", 32'(grant_b), 32'h0);

        push(8'h11, 2'd0);
        push(8'h22, 2'd1);
        push(8'h33, 2'd2);
        push(8'h44, 2'd3);
        push(8'h11, 2'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            clr = tbl[i].clr;
            cyc();
            chk("rr_grant", 32'(grant_a), 32'(tbl[i].grant));
            chk("rr_ack", 32'(ack_a), 32'(tbl[i].ack));
            chk("rr_q", 32'(q_a), 32'(tbl[i].q));
            chk("rr_last_id", 32'(id_a), 32'(tbl[i].id));
            chk("rr_busy", 32'(busy_a), 32'(tbl[i].busy));
            $display("row %0d: grant=%b ack=%b q=%02h last_id=%0d busy=%b",
                     i, grant_a, ack_a, q_a, id_a, busy_a);
        end

        // Wrap and skip: write from lane 2 leaves ptr=3, then 0101 picks 0 then 2.
        req = 4'b0100;
        push(8'h33, 2'd2);
        cyc();
        chk("wrap_g_lane2", 32'(grant_a), 32'b0100);
        cyc();
        req = 4'b0101;
        push(8'h11, 2'd0);
        cyc();
        chk("wrap_g_lane0", 32'(grant_a), 32'b0001);
        cyc();
        push(8'h33, 2'd2);
        cyc();
        chk("wrap_g_lane2_again", 32'(grant_a), 32'b0100);
        cyc();
        req = 4'b0000;

        // Abort: bring ptr to 1, grant lane 1, drop its request.
        req = 4'b0001;
        push(8'h11, 2'd0);
        cyc();
        cyc();
        req = 4'b0010;
        cyc();
        chk("abort_g", 32'(grant_a), 32'b0010);
        req = 4'b0000;
        cyc();
        chk("abort_grant", 32'(grant_a), 32'h0);
        chk("abort_ack", 32'(ack_a), 32'h0);
        chk("abort_q", 32'(q_a), 32'h11);
        chk("abort_last_id", 32'(id_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'h0);
        req = 4'b1110;
        push(8'h22, 2'd1);
        cyc();
        chk("abort_ptr_kept", 32'(grant_a), 32'b0010);
        cyc();
        req = 4'b0000;

        // Clear colliding with the write edge of lane 2.
        wdata[23:16] = 8'hA5;
        req = 4'b0100;
        cyc();
        chk("clr_g", 32'(grant_a), 32'b0100);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_q", 32'(q_a), 32'h0);
        chk("clr_ack", 32'(ack_a), 32'h0);
        chk("clr_last_id", 32'(id_a), 32'd2);
        chk("clr_grant", 32'(grant_a), 32'h0);
        req = 4'b1100;
        push(8'h44, 2'd3);
        cyc();
        chk("clr_ptr_advanced", 32'(grant_a), 32'b1000);
        cyc();
        req = 4'b0000;
        chk("clr_after_q", 32'(q_a), 32'h44);

        // Clear alone in idle.
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_idle_q", 32'(q_a), 32'h0);
        chk("clr_idle_busy", 32'(busy_a), 32'h0);
        chk("clr_idle_grant", 32'(grant_a), 32'h0);
        chk("clr_idle_last_id", 32'(id_a), 32'd3);
        req = 4'b0001;
        push(8'h11, 2'd0);
        cyc();
        chk("clr_idle_next_g", 32'(grant_a), 32'b0001);
        cyc();
        req = 4'b0000;
        wdata[23:16] = 8'h33;

        // Cooldown on instance b.
        reset   = 1'b0;
        mon_sel = 1;
        cyc();
        reset = 1'b1;
        req   = 4'b0001;
        push(8'h11, 2'd0);
        cyc();
        chk("cool_g", 32'(grant_b), 32'b0001);
        cyc();
        req = 4'b1111;
        chk("cool_ack", 32'(ack_b), 32'h1);
        chk("cool_busy0", 32'(busy_b), 32'h1);
        chk("cool_grant0", 32'(grant_b), 32'h0);
        for (int c = 1; c < 3; c++) begin
            cyc();
            chk("cool_busy", 32'(busy_b), 32'h1);
            chk("cool_no_grant", 32'(grant_b), 32'h0);
            chk("cool_no_ack", 32'(ack_b), 32'h0);
        end
        cyc();
        chk("cool_end_busy", 32'(busy_b), 32'h0);
        chk("cool_end_grant", 32'(grant_b), 32'h0);
        push(8'h22, 2'd1);
        cyc();
        chk("cool_next_g", 32'(grant_b), 32'b0010);
        cyc();
        req = 4'b0000;

        // Reset asserted while a grant is active.
        repeat (4) cyc();
        req = 4'b0100;
        cyc();
        chk("mr_g", 32'(grant_b), 32'b0100);
        chk("mr_q_before", 32'(q_b), 32'h22);
        reset = 1'b0;
        #1;
        chk("mr_grant", 32'(grant_b), 32'h0);
        chk("mr_q", 32'(q_b), 32'h0);
        chk("mr_ack", 32'(ack_b), 32'h0);
        chk("mr_busy", 32'(busy_b), 32'h0);
        chk("mr_last_id", 32'(id_b), 32'd0);
        cyc();
        chk("mr_ack_held", 32'(ack_b), 32'h0);
        chk("mr_q_held", 32'(q_b), 32'h0);
        req   = 4'b0000;
        reset = 1'b1;
        cyc();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
